stopwatch_timebase: RTL and testbench
=====================================

# stopwatch_timebase

Parametrised multi-channel clock divider that produces, per channel, a 50 % duty square wave and a one-cycle tick strobe from the single system clock. Each channel has a divisor that can be reprogrammed at run time. All channels share a global run/pause control and a synchronous restart. It replaces the fixed single-rate divider as the time base feeding the stopwatch counters, display scan and blink logic.

## Interface
- `N_CH`, 2: number of independent divider channels (1..8).
- `DIV_W`, 25: divisor/counter width in bits.
- `DEF_DIV`, 249999: reset value of every channel's divisor D (half-period = D+1 input cycles).
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start_stop`  in  1: global run (1) / pause (0).
- `ch_en`  in  N_CH: per-channel enable; 0 holds that channel cleared.
- `sync_clr`  in  1: synchronous restart of all channels.
- `div_load`  in  1: one-cycle strobe, write `div_val` into the pending divisor of channel `div_sel`.
- `div_sel`  in  max(1,$clog2(N_CH)): target channel for `div_load`.
- `div_val`  in  DIV_W: new divisor D (half-period minus 1).
- `out_clk`  out  N_CH: per-channel square wave, registered.
- `tick`  out  N_CH: per-channel one-cycle strobe at each `out_clk` toggle, registered.

## Operation
- Per channel: counter `cnt`, active divisor `act`, pending divisor `pend`.
- Reset: `cnt`=0, `out_clk`=0, `tick`=0, `act`=`pend`=DEF_DIV for all channels.
- Running (start_stop=1, ch_en[i]=1, no sync_clr): if `cnt`==`act`, then `cnt`<=0, `out_clk[i]` toggles, `tick[i]`<=1, `act`<=`pend`. Otherwise `cnt`<=`cnt`+1 and `tick[i]`<=0.
- Paused (start_stop=0, ch_en[i]=1): `cnt`, `out_clk[i]` and `act` hold. `tick[i]`<=0. Resume continues mid-period with no lost or extra count.
- Disabled (ch_en[i]=0): `cnt`<=0, `out_clk[i]`<=0, `tick[i]`<=0, `act`<=`pend`. Takes priority over pause.
- sync_clr=1: every channel `cnt`<=0, `out_clk`<=0, `tick`<=0, `act`<=`pend`. Highest priority after reset, regardless of start_stop or ch_en.
- div_load: `pend[div_sel]`<=`div_val`. A `div_sel` ≥ N_CH is ignored. `act` changes only at a wrap, on disable, or on sync_clr, so a period in progress is never truncated or glitched.
- div_load together with wrap/disable/sync_clr on the same channel in the same cycle: the newly loaded `div_val` goes directly into `act`.
- D=0: `out_clk` toggles every cycle (clk/2) and `tick` stays high continuously while running.
- Arithmetic is unsigned DIV_W bits. `cnt` never exceeds `act`, so no overflow path exists.

## Timing
- Period of `out_clk[i]` = 2·(D+1) clk cycles. Tick rate = clk/(D+1).
- First toggle after reset, sync_clr or enable with run=1: `out_clk` rises and `tick` pulses at the (D+1)-th rising edge after the clearing edge.
- `tick` and the `out_clk` edge appear in the same cycle, both registered. There is no combinational path from inputs to outputs.
- start_stop deassert: the next edge is frozen, including when deasserted in the wrap cycle (no wrap, no tick).
- A load takes effect from the period that starts after the next wrap. Worst-case latency is (old D+1) cycles.

## Structure
- A shared package holds `DIV_W`, `DEF_DIV` and the derived select width, plus named constants for the common stopwatch rates: 10 ms and 1 s half-periods at the board clock.
- Natural sub-module `timebase_ch`: one channel (cnt/act/pend, toggle, tick), instantiated N_CH times in a generate loop.
- The top level decodes `div_load`/`div_sel` into per-channel load strobes and fans out start_stop and sync_clr.

## Test plan
- Parameters N_CH=2, DEF_DIV=3. Release reset with run=1, ch_en=11 -> both `out_clk` toggle every 4 cycles (period 8); `tick` pulses on cycles 4, 8, 12.
- Pause 5 cycles at cnt=2, then resume -> next toggle arrives exactly 2 cycles after resume; no tick during the pause.
- Load div_val=1 to ch1 mid-period at cnt=1 -> ch1 completes its current 4-cycle half-period, then toggles every 2 cycles; ch0 is unchanged.
- Load D=0 on ch0 with sync_clr in the same cycle -> ch0 `out_clk` toggles every cycle from the first edge after clear, and `tick` stays high.
- Deassert ch_en[1] mid-count, reassert 3 cycles later -> `out_clk[1]`=0 while disabled; first toggle arrives D+1 cycles after re-enable. div_sel=3 loads are ignored.
- Assert rst asynchronously mid-period -> all outputs go to 0 immediately; divisors return to 3 even after earlier loads.

Source files
------------

// File: rtl/stopwatch_timebase_pkg.sv
// Shared constants, helpers and types for the stopwatch time base.
// Rate divisors assume the 25 MHz board clock.
package stopwatch_timebase_pkg;

    localparam int unsigned CLK_HZ        = 25_000_000;
    // Divisor D gives a half-period of D+1 input cycles.
    localparam int unsigned DIV_HALF_10MS = CLK_HZ / 100 - 1;
    localparam int unsigned DIV_HALF_1S   = CLK_HZ - 1;

    localparam int unsigned DIV_W   = $clog2(DIV_HALF_1S + 1);
    localparam int unsigned DEF_DIV = DIV_HALF_10MS;
    localparam int unsigned MAX_CH  = 8;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ChClear,
        ChHold,
        ChRun
    } ch_mode_e;

endpackage

// File: rtl/stopwatch_timebase_if.sv
// Control and output bundle of the stopwatch time base.
interface stopwatch_timebase_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned DIV_W = stopwatch_timebase_pkg::DIV_W,
    parameter int unsigned SEL_W = stopwatch_timebase_pkg::sel_width(N_CH)
);
    import stopwatch_timebase_pkg::*;

    logic             start_stop;
    logic [N_CH-1:0]  ch_en;
    logic             sync_clr;
    logic             div_load;
    logic [SEL_W-1:0] div_sel;
    logic [DIV_W-1:0] div_val;
    logic [N_CH-1:0]  out_clk;
    logic [N_CH-1:0]  tick;

    modport master (
        output start_stop, ch_en, sync_clr, div_load, div_sel, div_val,
        input  out_clk, tick
    );

    modport slave (
        input  start_stop, ch_en, sync_clr, div_load, div_sel, div_val,
        output out_clk, tick
    );

endinterface

// File: rtl/stopwatch_timebase_ch.sv
// One divider channel: counter, active and pending divisor, square wave and tick.
module stopwatch_timebase_ch #(
    parameter int unsigned      DIV_W   = stopwatch_timebase_pkg::DIV_W,
    parameter logic [DIV_W-1:0] DEF_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] val_i,
    output logic             out_clk_o,
    output logic             tick_o
);
    import stopwatch_timebase_pkg::*;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    ch_mode_e         mode;

    always_comb begin
        mode = ChRun;
        if (clr_i || !en_i) begin
            mode = ChClear;
        end else if (!run_i) begin
            mode = ChHold;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        out_d  = out_q;
        tick_d = 1'b0;
        // A load coinciding with a wrap or clear lands straight in act.
        pend_d = load_i ? val_i : pend_q;
        unique case (mode)
            ChClear: begin
                cnt_d = '0;
                out_d = 1'b0;
                act_d = pend_d;
            end
            ChHold: ;
            ChRun: begin
                if (cnt_q == act_q) begin
                    cnt_d  = '0;
                    out_d  = ~out_q;
                    tick_d = 1'b1;
                    act_d  = pend_d;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            act_q  <= DEF_DIV;
            pend_q <= DEF_DIV;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign out_clk_o = out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/stopwatch_timebase.sv
// Multi-channel stopwatch time base: per-channel square wave and tick with
// run-time reprogrammable divisors, shared run/pause and synchronous restart.
module stopwatch_timebase #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned DIV_W   = stopwatch_timebase_pkg::DIV_W,
    parameter int unsigned DEF_DIV = stopwatch_timebase_pkg::DEF_DIV
) (
    input logic                 clk,
    input logic                 rst,
    stopwatch_timebase_if.slave bus
);
    import stopwatch_timebase_pkg::*;

    if (N_CH < 1 || N_CH > MAX_CH || 64'(DEF_DIV) >= (64'd1 << DIV_W)) begin : g_bad_cfg
        $error("stopwatch_timebase: N_CH or DEF_DIV out of range");
    end

    logic [N_CH-1:0] load;
    logic [N_CH-1:0] out_clk;
    logic [N_CH-1:0] tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        // Selects at or above N_CH match no channel and are dropped.
        assign load[g] = bus.div_load && (32'(bus.div_sel) == g);

        stopwatch_timebase_ch #(
            .DIV_W  (DIV_W),
            .DEF_DIV(DIV_W'(DEF_DIV))
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .run_i    (bus.start_stop),
            .en_i     (bus.ch_en[g]),
            .clr_i    (bus.sync_clr),
            .load_i   (load[g]),
            .val_i    (bus.div_val),
            .out_clk_o(out_clk[g]),
            .tick_o   (tick[g])
        );
    end

    assign bus.out_clk = out_clk;
    assign bus.tick    = tick;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Scoreboard bench for stopwatch_timebase with DEF_DIV=3: expected tick events
// are queued by the stimulus and popped by a monitor whenever any tick fires.
module tb_stopwatch_timebase;

    localparam int unsigned DW = 25;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stopwatch_timebase_if #(.N_CH(2), .DIV_W(DW)) bus ();
    stopwatch_timebase_if #(.N_CH(3), .DIV_W(DW)) bus3 ();

    stopwatch_timebase #(.N_CH(2), .DIV_W(DW), .DEF_DIV(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    stopwatch_timebase #(.N_CH(3), .DIV_W(DW), .DEF_DIV(3)) dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bus3)
    );

    typedef struct {
        int         cyc;
        logic [1:0] tick;
        logic [1:0] oc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [1:0] t, input logic [1:0] o);
        ev_t e;
        e.cyc  = c;
        e.tick = t;
        e.oc   = o;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every cycle with any tick must match the head of the queue.
    initial begin : mon
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tick !== 2'b00) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_tick cyc=%0d tick=%b out=%b, want no tick",
                             cyc, bus.tick, bus.out_clk);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.tick !== bus.tick || e.oc !== bus.out_clk) begin
                        n_fail++;
                        $display("FAIL tick_event got cyc=%0d tick=%b out=%b want cyc=%0d tick=%b out=%b",
                                 cyc, bus.tick, bus.out_clk, e.cyc, e.tick, e.oc);
                    end
                end
            end
        end
    end

    initial begin : stim
        int c0, c1, c2;
        bus.start_stop  = 1'b1;
        bus.ch_en       = 2'b11;
        bus.sync_clr    = 1'b0;
        bus.div_load    = 1'b0;
        bus.div_sel     = 1'b0;
        bus.div_val     = '0;
        bus3.start_stop = 1'b1;
        bus3.ch_en      = 3'b111;
        bus3.sync_clr   = 1'b0;
        bus3.div_load   = 1'b0;
        bus3.div_sel    = 2'd0;
        bus3.div_val    = '0;

        repeat (3) @(negedge clk);
        check("rst_out_clk", 32'(bus.out_clk), 0);
        check("rst_tick", 32'(bus.tick), 0);

        // Free run, pause at cnt=2 for 5 cycles, then mid-period load of D=1 on ch1.
        c0 = cyc;
        push(c0 + 4,  2'b11, 2'b11);
        push(c0 + 8,  2'b11, 2'b00);
        push(c0 + 12, 2'b11, 2'b11);
        push(c0 + 21, 2'b11, 2'b00);
        push(c0 + 25, 2'b11, 2'b11);
        push(c0 + 27, 2'b10, 2'b01);
        push(c0 + 29, 2'b11, 2'b10);
        push(c0 + 31, 2'b10, 2'b00);
        push(c0 + 33, 2'b11, 2'b11);
        rst = 1'b1;
        bus3.div_load = 1'b1;
        bus3.div_sel  = 2'd3;
        bus3.div_val  = '0;
        @(negedge clk);
        bus3.div_load = 1'b0;

        // Out-of-range select must leave every divisor of dut3 at 3.
        wait_until(c0 + 4);
        check("oor_out_c4", 32'(bus3.out_clk), 32'h7);
        check("oor_tick_c4", 32'(bus3.tick), 32'h7);
        wait_until(c0 + 5);
        check("oor_out_c5", 32'(bus3.out_clk), 32'h7);
        check("oor_tick_c5", 32'(bus3.tick), 0);
        wait_until(c0 + 8);
        check("oor_out_c8", 32'(bus3.out_clk), 0);

        wait_until(c0 + 14);
        bus.start_stop = 1'b0;
        wait_until(c0 + 19);
        check("pause_hold_out", 32'(bus.out_clk), 32'h3);
        bus.start_stop = 1'b1;

        wait_until(c0 + 22);
        bus.div_load = 1'b1;
        bus.div_sel  = 1'b1;
        bus.div_val  = DW'(1);
        @(negedge clk);
        bus.div_load = 1'b0;

        // D=0 on ch0 loaded together with sync_clr.
        wait_until(c0 + 34);
        push(c0 + 36, 2'b01, 2'b01);
        push(c0 + 37, 2'b11, 2'b10);
        push(c0 + 38, 2'b01, 2'b11);
        push(c0 + 39, 2'b11, 2'b00);
        push(c0 + 40, 2'b01, 2'b01);
        bus.sync_clr = 1'b1;
        bus.div_load = 1'b1;
        bus.div_sel  = 1'b0;
        bus.div_val  = '0;
        @(negedge clk);
        bus.sync_clr = 1'b0;
        bus.div_load = 1'b0;
        check("clr_out_clk", 32'(bus.out_clk), 0);

        // Restore ch0 to D=3 via sync_clr, then disable ch1 for 3 cycles.
        wait_until(c0 + 40);
        c1 = c0 + 41;
        push(c1 + 2,  2'b10, 2'b10);
        push(c1 + 4,  2'b11, 2'b01);
        push(c1 + 6,  2'b10, 2'b11);
        push(c1 + 8,  2'b01, 2'b00);
        push(c1 + 11, 2'b10, 2'b10);
        push(c1 + 12, 2'b01, 2'b11);
        push(c1 + 13, 2'b10, 2'b01);
        bus.sync_clr = 1'b1;
        bus.div_load = 1'b1;
        bus.div_sel  = 1'b0;
        bus.div_val  = DW'(3);
        @(negedge clk);
        bus.sync_clr = 1'b0;
        bus.div_load = 1'b0;

        wait_until(c1 + 6);
        bus.ch_en = 2'b01;
        wait_until(c1 + 7);
        check("dis_out1", 32'(bus.out_clk[1]), 0);
        check("dis_tick1", 32'(bus.tick[1]), 0);
        wait_until(c1 + 9);
        check("dis_out1_late", 32'(bus.out_clk[1]), 0);
        bus.ch_en = 2'b11;

        // Asynchronous reset mid-period; ch1 must come back at D=3.
        wait_until(c1 + 14);
        check("pre_arst_out", 32'(bus.out_clk), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_clk", 32'(bus.out_clk), 0);
        check("arst_tick", 32'(bus.tick), 0);
        @(negedge clk);
        @(negedge clk);
        c2 = cyc;
        push(c2 + 4,  2'b11, 2'b11);
        push(c2 + 8,  2'b11, 2'b00);
        push(c2 + 12, 2'b11, 2'b11);
        rst = 1'b1;

        wait_until(c2 + 14);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events got=%0d want=0 (next cyc %0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
